// File: rtl/pipe_cmd_tracker.sv
// Tracks up to NUM_SLOTS host commands through target request, completion or timeout, and tagged response.
// Latency: accept -> req_valid 1 cycle; completion -> rsp_valid 1 cycle; req_*/rsp_* come only from registered state.
// Backpressure: cmd_ready low when no slot is free or a reset command is in flight; req_*/rsp_* hold while stalled.
module pipe_cmd_tracker #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TAG_W       = 8,
  parameter int NUM_SLOTS   = 4,
  parameter int TIMEOUT_CYC = 1024,
  parameter int TS_W        = 32
) (
  input  logic                         user_clk,
  input  logic                         sys_rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [7:0]                   cmd_type,
  input  logic [ADDR_W-1:0]            cmd_addr,
  input  logic [DATA_W-1:0]            cmd_data,
  input  logic [TAG_W-1:0]             cmd_tag,
  output logic                         req_valid,
  input  logic                         req_ready,
  output logic                         req_write,
  output logic [ADDR_W-1:0]            req_addr,
  output logic [DATA_W-1:0]            req_data,
  output logic [$clog2(NUM_SLOTS)-1:0] req_slot,
  input  logic                         cpl_valid,
  input  logic [$clog2(NUM_SLOTS)-1:0] cpl_slot,
  input  logic [DATA_W-1:0]            cpl_data,
  input  logic [7:0]                   cpl_status,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [7:0]                   rsp_type,
  output logic [DATA_W-1:0]            rsp_data,
  output logic [TAG_W-1:0]             rsp_tag,
  output logic [7:0]                   rsp_status,
  output logic [TS_W-1:0]              rsp_timestamp,
  output logic [$clog2(NUM_SLOTS):0]   outstanding,
  output logic [15:0]                  stale_cpl_cnt
);

  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam int CNT_W  = SLOT_W + 1;
  localparam int TMR_W  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [7:0] TYPE_RD  = 8'h01;
  localparam logic [7:0] TYPE_WR  = 8'h02;
  localparam logic [7:0] TYPE_RST = 8'h03;
  localparam logic [7:0] ST_OK    = 8'h00;
  localparam logic [7:0] ST_UNSUP = 8'h01;
  localparam logic [7:0] ST_TMO   = 8'h02;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_FREE, S_ISSUE, S_WAIT, S_DONE} slot_st_t;

  typedef struct packed {
    logic [7:0]        typ;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic [7:0]        status;
    logic [DATA_W-1:0] rdata;
    logic [TS_W-1:0]   ts;
    logic [TMR_W-1:0]  timer;
  } slot_t;

  slot_st_t          st_q [NUM_SLOTS];
  slot_st_t          st_d [NUM_SLOTS];
  slot_t             sl_q [NUM_SLOTS];
  slot_t             sl_d [NUM_SLOTS];
  logic [TS_W-1:0]   ts_q;
  logic [TS_W-1:0]   ts_next;
  logic [15:0]       stale_q;
  logic [15:0]       stale_d;
  logic              ready_en_q;
  logic              req_lock_q;
  logic              rsp_lock_q;
  logic [SLOT_W-1:0] req_sel_q;
  logic [SLOT_W-1:0] rsp_sel_q;

  logic              any_free;
  logic              any_issue;
  logic              any_done;
  logic              rst_busy;
  logic [SLOT_W-1:0] free_idx;
  logic [SLOT_W-1:0] issue_idx;
  logic [SLOT_W-1:0] done_idx;
  logic [SLOT_W-1:0] req_sel;
  logic [SLOT_W-1:0] rsp_sel;
  logic [CNT_W-1:0]  busy_cnt;
  logic              cmd_acc;
  logic              req_hs;
  logic              rsp_hs;
  logic              cpl_hit;

  // Descending scan leaves the lowest matching index in each *_idx.
  always_comb begin
    any_free  = 1'b0;
    any_issue = 1'b0;
    any_done  = 1'b0;
    rst_busy  = 1'b0;
    free_idx  = '0;
    issue_idx = '0;
    done_idx  = '0;
    busy_cnt  = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (st_q[i] == S_FREE) begin
        any_free = 1'b1;
        free_idx = SLOT_W'(i);
      end
      if (st_q[i] == S_ISSUE) begin
        any_issue = 1'b1;
        issue_idx = SLOT_W'(i);
      end
      if (st_q[i] == S_DONE) begin
        any_done = 1'b1;
        done_idx = SLOT_W'(i);
      end
      if (st_q[i] != S_FREE) begin
        busy_cnt = busy_cnt + CNT_W'(1);
        if (sl_q[i].typ == TYPE_RST) rst_busy = 1'b1;
      end
    end
  end

  // A stalled request/response keeps its slot even if a lower index becomes eligible.
  assign req_sel = req_lock_q ? req_sel_q : issue_idx;
  assign rsp_sel = rsp_lock_q ? rsp_sel_q : done_idx;

  assign cmd_ready     = ready_en_q & any_free & ~rst_busy;
  assign req_valid     = any_issue;
  assign req_write     = any_issue & (sl_q[req_sel].typ == TYPE_WR);
  assign req_addr      = any_issue ? sl_q[req_sel].addr : '0;
  assign req_data      = any_issue ? sl_q[req_sel].data : '0;
  assign req_slot      = any_issue ? req_sel : '0;
  assign rsp_valid     = any_done;
  assign rsp_type      = any_done ? (sl_q[rsp_sel].typ | 8'h80) : 8'h00;
  assign rsp_data      = any_done ? sl_q[rsp_sel].rdata : '0;
  assign rsp_tag       = any_done ? sl_q[rsp_sel].tag : '0;
  assign rsp_status    = any_done ? sl_q[rsp_sel].status : 8'h00;
  assign rsp_timestamp = any_done ? sl_q[rsp_sel].ts : '0;
  assign outstanding   = busy_cnt;
  assign stale_cpl_cnt = stale_q;

  always_comb begin
    cmd_acc = cmd_valid & cmd_ready;
    req_hs  = any_issue & req_ready;
    rsp_hs  = any_done & rsp_ready;
    cpl_hit = cpl_valid && (st_q[cpl_slot] == S_WAIT) && (sl_q[cpl_slot].typ != TYPE_RST);
    ts_next = ts_q + TS_W'(1);
    stale_d = stale_q;
    if (cpl_valid && !cpl_hit && (stale_q != 16'hFFFF)) stale_d = stale_q + 16'd1;

    for (int i = 0; i < NUM_SLOTS; i++) begin
      st_d[i] = st_q[i];
      sl_d[i] = sl_q[i];
      case (st_q[i])
        S_FREE: begin
          if (cmd_acc && (free_idx == SLOT_W'(i))) begin
            sl_d[i].typ    = cmd_type;
            sl_d[i].addr   = cmd_addr;
            sl_d[i].data   = cmd_data;
            sl_d[i].tag    = cmd_tag;
            sl_d[i].status = ST_OK;
            sl_d[i].rdata  = '0;
            sl_d[i].timer  = '0;
            if ((cmd_type == TYPE_RD) || (cmd_type == TYPE_WR)) begin
              st_d[i] = S_ISSUE;
            end else if (cmd_type == TYPE_RST) begin
              st_d[i] = S_WAIT;
            end else begin
              st_d[i]        = S_DONE;
              sl_d[i].status = ST_UNSUP;
              sl_d[i].ts     = ts_next;
            end
          end
        end
        S_ISSUE: begin
          if (req_hs && (req_sel == SLOT_W'(i))) begin
            st_d[i]       = S_WAIT;
            sl_d[i].timer = '0;
          end
        end
        S_WAIT: begin
          if (sl_q[i].typ == TYPE_RST) begin
            // Only this slot is still occupied: everything ahead has drained.
            if (busy_cnt == CNT_W'(1)) begin
              st_d[i]        = S_DONE;
              sl_d[i].status = ST_OK;
              sl_d[i].rdata  = '0;
              sl_d[i].ts     = ts_next;
            end
          end else if (cpl_hit && (cpl_slot == SLOT_W'(i))) begin
            st_d[i]        = S_DONE;
            sl_d[i].status = cpl_status;
            sl_d[i].rdata  = cpl_data;
            sl_d[i].ts     = ts_next;
          end else if (sl_q[i].timer == TMR_LAST) begin
            st_d[i]        = S_DONE;
            sl_d[i].status = ST_TMO;
            sl_d[i].rdata  = '0;
            sl_d[i].ts     = ts_next;
          end else begin
            sl_d[i].timer = sl_q[i].timer + TMR_W'(1);
          end
        end
        S_DONE: begin
          if (rsp_hs && (rsp_sel == SLOT_W'(i))) st_d[i] = S_FREE;
        end
        default: st_d[i] = S_FREE;
      endcase
    end
  end

  always_ff @(posedge user_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        st_q[i] <= S_FREE;
        sl_q[i] <= '0;
      end
      ts_q       <= '0;
      stale_q    <= '0;
      ready_en_q <= 1'b0;
      req_lock_q <= 1'b0;
      rsp_lock_q <= 1'b0;
      req_sel_q  <= '0;
      rsp_sel_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        st_q[i] <= st_d[i];
        sl_q[i] <= sl_d[i];
      end
      ts_q       <= ts_next;
      stale_q    <= stale_d;
      ready_en_q <= 1'b1;
      req_lock_q <= any_issue & ~req_ready;
      rsp_lock_q <= any_done & ~rsp_ready;
      req_sel_q  <= req_sel;
      rsp_sel_q  <= rsp_sel;
    end
  end

endmodule

// File: tb/tb_pipe_cmd_tracker.sv
// Bench for pipe_cmd_tracker: vector table of single round trips, a response scoreboard,
// and hand-written sequences for multi-outstanding, timeout, reset command, backpressure and async reset.
module tb_pipe_cmd_tracker;
  localparam int TMO = 64;

  logic        user_clk   = 1'b0;
  logic        sys_rst_n  = 1'b0;
  logic        cmd_valid  = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_type   = 8'h00;
  logic [31:0] cmd_addr   = 32'h0;
  logic [31:0] cmd_data   = 32'h0;
  logic [7:0]  cmd_tag    = 8'h00;
  logic        req_valid;
  logic        req_ready  = 1'b0;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_slot;
  logic        cpl_valid  = 1'b0;
  logic [1:0]  cpl_slot   = 2'd0;
  logic [31:0] cpl_data   = 32'h0;
  logic [7:0]  cpl_status = 8'h00;
  logic        rsp_valid;
  logic        rsp_ready  = 1'b0;
  logic [7:0]  rsp_type;
  logic [31:0] rsp_data;
  logic [7:0]  rsp_tag;
  logic [7:0]  rsp_status;
  logic [31:0] rsp_timestamp;
  logic [2:0]  outstanding;
  logic [15:0] stale_cpl_cnt;

  pipe_cmd_tracker #(
    .ADDR_W(32), .DATA_W(32), .TAG_W(8), .NUM_SLOTS(4), .TIMEOUT_CYC(TMO), .TS_W(32)
  ) dut (
    .user_clk(user_clk), .sys_rst_n(sys_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_tag(cmd_tag),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data), .req_slot(req_slot),
    .cpl_valid(cpl_valid), .cpl_slot(cpl_slot), .cpl_data(cpl_data), .cpl_status(cpl_status),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_type(rsp_type), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_status(rsp_status), .rsp_timestamp(rsp_timestamp),
    .outstanding(outstanding), .stale_cpl_cnt(stale_cpl_cnt)
  );

  always #5 user_clk = ~user_clk;

  // Cycles since reset release; equals the expected timestamp counter value.
  logic [31:0] cyc;
  always @(posedge user_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) cyc <= 32'd0;
    else            cyc <= cyc + 32'd1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic fail_to(input string nm);
    checks++;
    errors++;
    $display("FAIL %s act=wait_expired exp=event", nm);
  endtask

  typedef struct {
    logic [7:0]  typ;
    logic [31:0] data;
    logic [7:0]  tag;
    logic [7:0]  status;
    logic        chk_ts;
    logic [31:0] ts;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  task automatic push_exp(input logic [7:0] t, input logic [31:0] d, input logic [7:0] tg,
                          input logic [7:0] st, input logic ck, input logic [31:0] ts);
    exp_t e;
    e.typ = t; e.data = d; e.tag = tg; e.status = st; e.chk_ts = ck; e.ts = ts;
    sb_q.push_back(e);
  endtask

  always @(negedge user_clk) begin
    if (sys_rst_n && rsp_valid && rsp_ready) begin
      chk("rsp_expected", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        chk("rsp_type", rsp_type, mon_e.typ);
        chk("rsp_data", rsp_data, mon_e.data);
        chk("rsp_tag", rsp_tag, mon_e.tag);
        chk("rsp_status", rsp_status, mon_e.status);
        if (mon_e.chk_ts) chk("rsp_timestamp", rsp_timestamp, mon_e.ts);
      end
    end
  end

  task automatic send_cmd(input logic [7:0] t, input logic [31:0] a, input logic [31:0] d,
                          input logic [7:0] tg);
    int n = 0;
    @(posedge user_clk); #1;
    cmd_valid = 1'b1; cmd_type = t; cmd_addr = a; cmd_data = d; cmd_tag = tg;
    @(negedge user_clk);
    while (!cmd_ready && n < 200) begin
      @(negedge user_clk);
      n++;
    end
    if (!cmd_ready) fail_to("cmd_ready_wait");
    @(posedge user_clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic take_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] s);
    int n = 0;
    @(negedge user_clk);
    while (!req_valid && n < 200) begin
      @(negedge user_clk);
      n++;
    end
    if (!req_valid) begin
      fail_to("req_wait");
    end else begin
      chk("req_write", req_write, w);
      chk("req_addr", req_addr, a);
      chk("req_data", req_data, d);
      chk("req_slot", req_slot, s);
    end
    req_ready = 1'b1;
    @(posedge user_clk); #1;
    req_ready = 1'b0;
  endtask

  task automatic complete(input logic [1:0] s, input logic [31:0] d, input logic [7:0] st);
    cpl_valid = 1'b1; cpl_slot = s; cpl_data = d; cpl_status = st;
    @(posedge user_clk); #1;
    cpl_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge user_clk);
    while (outstanding != 0 && n < 500) begin
      @(negedge user_clk);
      n++;
    end
    if (outstanding != 0) fail_to("idle_wait");
  endtask

  typedef struct {
    logic [7:0]  typ;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  tag;
    logic [31:0] cdata;
    logic [7:0]  cstat;
    logic        has_req;
    logic        exp_wr;
    logic [7:0]  exp_rtype;
    logic [7:0]  exp_rstat;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h01, 32'h1000, 32'h0,        8'h5A, 32'hDEADBEEF, 8'h00, 1'b1, 1'b0, 8'h81, 8'h00, 32'hDEADBEEF};
    vecs[1] = '{8'h02, 32'h2004, 32'hCAFEF00D, 8'h11, 32'h0,        8'h00, 1'b1, 1'b1, 8'h82, 8'h00, 32'h0};
    vecs[2] = '{8'h01, 32'h3000, 32'h0,        8'h22, 32'h12345678, 8'h05, 1'b1, 1'b0, 8'h81, 8'h05, 32'h12345678};
    vecs[3] = '{8'h07, 32'h0,    32'h0,        8'h33, 32'h0,        8'h00, 1'b0, 1'b0, 8'h87, 8'h01, 32'h0};
    vecs[4] = '{8'hFF, 32'h44,   32'h9,        8'h44, 32'h0,        8'h00, 1'b0, 1'b0, 8'hFF, 8'h01, 32'h0};
    vecs[5] = '{8'h02, 32'h5008, 32'h0BADF00D, 8'h55, 32'h0,        8'hE0, 1'b1, 1'b1, 8'h82, 8'hE0, 32'h0};

    // Reset state
    #3;
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_req_valid", req_valid, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_outstanding", outstanding, 3'd0);
    chk("rst_stale", stale_cpl_cnt, 16'd0);
    repeat (3) @(negedge user_clk);
    sys_rst_n = 1'b1;
    rsp_ready = 1'b1;

    // Single-command round trips
    for (int i = 0; i < 6; i++) begin
      send_cmd(vecs[i].typ, vecs[i].addr, vecs[i].wdata, vecs[i].tag);
      if (vecs[i].has_req) begin
        @(negedge user_clk);
        chk("req_latency", req_valid, 1'b1);
        take_req(vecs[i].exp_wr, vecs[i].addr, vecs[i].wdata, 2'd0);
        push_exp(vecs[i].exp_rtype, vecs[i].exp_rdata, vecs[i].tag, vecs[i].exp_rstat, 1'b1, cyc + 32'd1);
        cpl_valid = 1'b1; cpl_slot = 2'd0; cpl_data = vecs[i].cdata; cpl_status = vecs[i].cstat;
        @(negedge user_clk);
        chk("rsp_before_cpl_edge", rsp_valid, 1'b0);
        @(posedge user_clk); #1;
        cpl_valid = 1'b0;
        @(negedge user_clk);
        chk("rsp_latency", rsp_valid, 1'b1);
      end else begin
        push_exp(vecs[i].exp_rtype, vecs[i].exp_rdata, vecs[i].tag, vecs[i].exp_rstat, 1'b1, cyc);
        @(negedge user_clk);
        chk("unsup_no_req", req_valid, 1'b0);
        chk("unsup_rsp_latency", rsp_valid, 1'b1);
      end
      wait_idle();
    end

    // Four outstanding reads, completed out of order
    for (int i = 0; i < 4; i++) send_cmd(8'h01, 32'h100 * (i + 1), 32'h0, 8'hA0 + 8'(i));
    @(negedge user_clk);
    chk("full_cmd_ready", cmd_ready, 1'b0);
    chk("full_outstanding", outstanding, 3'd4);
    for (int i = 0; i < 4; i++) take_req(1'b0, 32'h100 * (i + 1), 32'h0, 2'(i));
    begin
      logic [1:0] order [4];
      order[0] = 2'd3; order[1] = 2'd1; order[2] = 2'd0; order[3] = 2'd2;
      for (int k = 0; k < 4; k++) begin
        push_exp(8'h81, 32'hC0DE0000 + 32'(order[k]), 8'hA0 + 8'(order[k]), 8'h00, 1'b1, cyc + 32'd1);
        complete(order[k], 32'hC0DE0000 + 32'(order[k]), 8'h00);
        repeat (3) @(posedge user_clk);
        #1;
      end
    end
    wait_idle();

    // Timeout, then a late completion counted as stale
    send_cmd(8'h01, 32'h40, 32'h0, 8'h77);
    take_req(1'b0, 32'h40, 32'h0, 2'd0);
    push_exp(8'h81, 32'h0, 8'h77, 8'h02, 1'b1, cyc + 32'(TMO));
    repeat (TMO - 1) @(posedge user_clk);
    @(negedge user_clk);
    chk("tmo_not_early", rsp_valid, 1'b0);
    @(negedge user_clk);
    chk("tmo_fires", rsp_valid, 1'b1);
    wait_idle();
    complete(2'd0, 32'h999, 8'h00);
    repeat (3) @(posedge user_clk);
    @(negedge user_clk);
    chk("stale_after_tmo", stale_cpl_cnt, 16'd1);
    chk("stale_no_slot", outstanding, 3'd0);

    // Reset command behind two pending reads
    send_cmd(8'h01, 32'h500, 32'h0, 8'hB0);
    send_cmd(8'h01, 32'h504, 32'h0, 8'hB1);
    take_req(1'b0, 32'h500, 32'h0, 2'd0);
    take_req(1'b0, 32'h504, 32'h0, 2'd1);
    send_cmd(8'h03, 32'h0, 32'h0, 8'hC3);
    complete(2'd2, 32'h55, 8'h00);
    @(negedge user_clk);
    chk("rstcmd_blocks", cmd_ready, 1'b0);
    chk("rstcmd_outstanding", outstanding, 3'd3);
    chk("rstcmd_stale", stale_cpl_cnt, 16'd2);
    chk("rstcmd_no_req", req_valid, 1'b0);
    @(posedge user_clk); #1;
    push_exp(8'h81, 32'hB1B1B1B1, 8'hB1, 8'h00, 1'b1, cyc + 32'd1);
    complete(2'd1, 32'hB1B1B1B1, 8'h00);
    repeat (3) @(posedge user_clk);
    #1;
    chk("rstcmd_still_blocks", cmd_ready, 1'b0);
    push_exp(8'h81, 32'hB0B0B0B0, 8'hB0, 8'h00, 1'b1, cyc + 32'd1);
    push_exp(8'h83, 32'h0, 8'hC3, 8'h00, 1'b1, cyc + 32'd3);
    complete(2'd0, 32'hB0B0B0B0, 8'h00);
    wait_idle();
    @(negedge user_clk);
    chk("rstcmd_unblocks", cmd_ready, 1'b1);

    // Response backpressure with two DONE slots
    @(posedge user_clk); #1;
    rsp_ready = 1'b0;
    send_cmd(8'h01, 32'h600, 32'h0, 8'hD0);
    send_cmd(8'h01, 32'h604, 32'h0, 8'hD1);
    take_req(1'b0, 32'h600, 32'h0, 2'd0);
    take_req(1'b0, 32'h604, 32'h0, 2'd1);
    push_exp(8'h81, 32'hD0D0D0D0, 8'hD0, 8'h00, 1'b1, cyc + 32'd1);
    complete(2'd0, 32'hD0D0D0D0, 8'h00);
    push_exp(8'h81, 32'hD1D1D1D1, 8'hD1, 8'h00, 1'b1, cyc + 32'd1);
    complete(2'd1, 32'hD1D1D1D1, 8'h00);
    for (int k = 0; k < 3; k++) begin
      @(negedge user_clk);
      chk("bp_valid", rsp_valid, 1'b1);
      chk("bp_tag_hold", rsp_tag, 8'hD0);
      chk("bp_data_hold", rsp_data, 32'hD0D0D0D0);
    end
    @(posedge user_clk); #1;
    rsp_ready = 1'b1;
    @(negedge user_clk);
    @(negedge user_clk);
    chk("bp_next_valid", rsp_valid, 1'b1);
    chk("bp_next_tag", rsp_tag, 8'hD1);
    wait_idle();

    // Asynchronous reset with three busy slots
    send_cmd(8'h01, 32'h700, 32'h0, 8'hE0);
    send_cmd(8'h02, 32'h704, 32'h1, 8'hE1);
    send_cmd(8'h01, 32'h708, 32'h0, 8'hE2);
    take_req(1'b0, 32'h700, 32'h0, 2'd0);
    @(negedge user_clk);
    chk("pre_rst_outstanding", outstanding, 3'd3);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("arst_cmd_ready", cmd_ready, 1'b0);
    chk("arst_req_valid", req_valid, 1'b0);
    chk("arst_req_addr", req_addr, 32'h0);
    chk("arst_rsp_valid", rsp_valid, 1'b0);
    chk("arst_rsp_type", rsp_type, 8'h00);
    chk("arst_rsp_ts", rsp_timestamp, 32'h0);
    chk("arst_outstanding", outstanding, 3'd0);
    chk("arst_stale", stale_cpl_cnt, 16'd0);
    repeat (2) @(negedge user_clk);
    sys_rst_n = 1'b1;
    send_cmd(8'h01, 32'h800, 32'h0, 8'hF1);
    take_req(1'b0, 32'h800, 32'h0, 2'd0);
    push_exp(8'h81, 32'hF1F1F1F1, 8'hF1, 8'h00, 1'b1, cyc + 32'd1);
    complete(2'd0, 32'hF1F1F1F1, 8'h00);
    wait_idle();

    repeat (3) @(negedge user_clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
